// File: rtl/bounce_seq_checker_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bounce_seq_checker_if
// Purpose  : Bundles the sample stream from the bounce counter and the
//            status outputs of bounce_seq_checker into one interface.
// Ports    : in_valid, count_in            - driven by the upstream side
//            locked, dir, at_peak, at_trough,
//            trip_cnt, err, err_code       - driven by the checker
// Modports : master - upstream/consumer view, slave - checker view
// Revision : 1.0 - initial release
// ============================================================================
interface bounce_seq_checker_if #(
  parameter int WIDTH = 4,
  parameter int TRIPW = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] count_in;
  logic             locked;
  logic             dir;
  logic             at_peak;
  logic             at_trough;
  logic [TRIPW-1:0] trip_cnt;
  logic             err;
  logic [1:0]       err_code;

  modport master (
    output in_valid, count_in,
    input  locked, dir, at_peak, at_trough, trip_cnt, err, err_code
  );

  modport slave (
    input  in_valid, count_in,
    output locked, dir, at_peak, at_trough, trip_cnt, err, err_code
  );
endinterface
`default_nettype wire

// File: rtl/bounce_seq_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bounce_seq_checker
// Purpose  : Monitors the up/down sweep of a bounce counter between LO and HI.
//            Locks onto the sweep, reports direction, peak/trough pulses and
//            completed round trips, and latches the first illegal step.
// Ports    : clk  - clock
//            rst  - synchronous active-high reset
//            bus  - slave modport: in_valid/count_in in, status out
//                   (locked, dir, at_peak, at_trough, trip_cnt, err, err_code)
// Revision : 1.0 - initial release
// ============================================================================
module bounce_seq_checker #(
  parameter int WIDTH = 4,
  parameter int LO    = 0,
  parameter int HI    = 6,
  parameter int TRIPW = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  bounce_seq_checker_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_UP    = 2'd1,
    ST_DOWN  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [1:0] c_code_step  = 2'd1;
  localparam logic [1:0] c_code_range = 2'd2;
  localparam logic [1:0] c_code_dir   = 2'd3;

  // All step arithmetic is one bit wider than the sample so that prev-1 at
  // zero (or prev+1 at all-ones) can never alias onto a legal value.
  localparam logic [WIDTH:0]   c_lo      = (WIDTH+1)'(LO);
  localparam logic [WIDTH:0]   c_hi      = (WIDTH+1)'(HI);
  localparam logic [WIDTH:0]   c_one_ext = (WIDTH+1)'(1);
  localparam logic [TRIPW-1:0] c_trip_one = TRIPW'(1);
  localparam logic [TRIPW-1:0] c_trip_max = '1;

  state_t           r_state;
  logic [WIDTH-1:0] r_prev;
  logic             r_seen_peak;
  logic [TRIPW-1:0] r_trip_cnt;
  logic [1:0]       r_err_code;
  logic             r_err;
  logic             r_locked;
  logic             r_dir;
  logic             r_at_peak;
  logic             r_at_trough;

  logic [WIDTH:0] w_s;
  logic [WIDTH:0] w_inc;
  logic [WIDTH:0] w_dec;
  logic           w_oor;

  assign w_s   = {1'b0, bus.count_in};
  assign w_inc = {1'b0, r_prev} + c_one_ext;
  assign w_dec = {1'b0, r_prev} - c_one_ext;
  // s < LO is written as s+1 <= LO so the compare stays meaningful when LO=0.
  assign w_oor = ((w_s + c_one_ext) <= c_lo) || (w_s > c_hi);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SYNC;
      r_prev      <= '0;
      r_seen_peak <= 1'b0;
      r_trip_cnt  <= '0;
      r_err_code  <= 2'd0;
      r_err       <= 1'b0;
      r_locked    <= 1'b0;
      r_dir       <= 1'b0;
      r_at_peak   <= 1'b0;
      r_at_trough <= 1'b0;
    end else begin
      // Pulses are single-cycle unless re-asserted below.
      r_at_peak   <= 1'b0;
      r_at_trough <= 1'b0;
      if (bus.in_valid) begin
        case (r_state)
          ST_SYNC: begin
            if (w_oor) begin
              r_state    <= ST_FAULT;
              r_err      <= 1'b1;
              r_err_code <= c_code_range;
            end else if (w_s == c_lo) begin
              r_prev   <= bus.count_in;
              r_state  <= ST_UP;
              r_locked <= 1'b1;
              r_dir    <= 1'b0;
            end else if (w_s == c_hi) begin
              // Locking at the top counts as having seen the peak, but no
              // peak pulse is given since the rise was never observed.
              r_prev      <= bus.count_in;
              r_state     <= ST_DOWN;
              r_locked    <= 1'b1;
              r_dir       <= 1'b1;
              r_seen_peak <= 1'b1;
            end
          end

          ST_UP: begin
            if (w_oor) begin
              r_state    <= ST_FAULT;
              r_err      <= 1'b1;
              r_locked   <= 1'b0;
              r_err_code <= c_code_range;
            end else if (w_s == w_inc) begin
              r_prev <= bus.count_in;
              if (w_s == c_hi) begin
                r_at_peak   <= 1'b1;
                r_seen_peak <= 1'b1;
                r_state     <= ST_DOWN;
                r_dir       <= 1'b1;
              end
            end else if (w_s == w_dec) begin
              r_state    <= ST_FAULT;
              r_err      <= 1'b1;
              r_locked   <= 1'b0;
              r_err_code <= c_code_dir;
            end else begin
              r_state    <= ST_FAULT;
              r_err      <= 1'b1;
              r_locked   <= 1'b0;
              r_err_code <= c_code_step;
            end
          end

          ST_DOWN: begin
            if (w_oor) begin
              r_state    <= ST_FAULT;
              r_err      <= 1'b1;
              r_locked   <= 1'b0;
              r_err_code <= c_code_range;
            end else if (w_s == w_dec) begin
              r_prev <= bus.count_in;
              if (w_s == c_lo) begin
                r_at_trough <= 1'b1;
                r_state     <= ST_UP;
                r_dir       <= 1'b0;
                if (r_seen_peak) begin
                  if (r_trip_cnt != c_trip_max) begin
                    r_trip_cnt <= r_trip_cnt + c_trip_one;
                  end
                  r_seen_peak <= 1'b0;
                end
              end
            end else if (w_s == w_inc) begin
              r_state    <= ST_FAULT;
              r_err      <= 1'b1;
              r_locked   <= 1'b0;
              r_err_code <= c_code_dir;
            end else begin
              r_state    <= ST_FAULT;
              r_err      <= 1'b1;
              r_locked   <= 1'b0;
              r_err_code <= c_code_step;
            end
          end

          ST_FAULT: begin
            // Absorbing: only rst leaves, first error code stays frozen.
            r_state <= ST_FAULT;
          end
        endcase
      end
    end
  end

  assign bus.locked    = r_locked;
  assign bus.dir       = r_dir;
  assign bus.at_peak   = r_at_peak;
  assign bus.at_trough = r_at_trough;
  assign bus.trip_cnt  = r_trip_cnt;
  assign bus.err       = r_err;
  assign bus.err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_bounce_seq_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bounce_seq_checker
// Purpose  : Directed self-checking bench for bounce_seq_checker. Two DUTs
//            share the stimulus: dut_a (TRIPW=8) and dut_b (TRIPW=2, used for
//            saturation and mid-sweep reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bounce_seq_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bounce_seq_checker_if #(.WIDTH(4), .TRIPW(8)) bus_a ();
  bounce_seq_checker_if #(.WIDTH(4), .TRIPW(2)) bus_b ();

  bounce_seq_checker #(.WIDTH(4), .LO(0), .HI(6), .TRIPW(8)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave)
  );
  bounce_seq_checker #(.WIDTH(4), .LO(0), .HI(6), .TRIPW(2)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Apply one sample to both DUTs, then sample outputs 1 ns after the edge.
  task automatic step(input logic v, input logic [3:0] c);
    bus_a.in_valid = v;
    bus_a.count_in = c;
    bus_b.in_valid = v;
    bus_b.count_in = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 4'd0);
    rst = 1'b0;
  endtask

  // Rising half 1..6 then falling half 5..0.
  task automatic sweep_tail();
    for (int v = 1; v <= 6; v++) step(1'b1, 4'(v));
    for (int v = 5; v >= 0; v--) step(1'b1, 4'(v));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 4'd0);  // rst wins over a valid LO sample
    rst = 1'b0;
    tests_run++; if (bus_a.locked !== 1'b0) begin tests_failed++; $display("FAIL reset_locked: got %b want 0", bus_a.locked); end
    tests_run++; if (bus_a.dir !== 1'b0) begin tests_failed++; $display("FAIL reset_dir: got %b want 0", bus_a.dir); end
    tests_run++; if (bus_a.at_peak !== 1'b0) begin tests_failed++; $display("FAIL reset_peak: got %b want 0", bus_a.at_peak); end
    tests_run++; if (bus_a.at_trough !== 1'b0) begin tests_failed++; $display("FAIL reset_trough: got %b want 0", bus_a.at_trough); end
    tests_run++; if (bus_a.trip_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_trip: got %0d want 0", bus_a.trip_cnt); end
    tests_run++; if (bus_a.err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", bus_a.err); end
    tests_run++; if (bus_a.err_code !== 2'd0) begin tests_failed++; $display("FAIL reset_code: got %0d want 0", bus_a.err_code); end
  endtask

  task automatic test_full_sweep();
    int seq [13] = '{0, 1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 0};
    logic exp_peak, exp_trough, exp_dir;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(1'b1, 4'(seq[i]));
      exp_peak   = (i == 6);
      exp_trough = (i == 12);
      exp_dir    = (i >= 6) && (i < 12);
      tests_run++; if (bus_a.locked !== 1'b1) begin tests_failed++; $display("FAIL sweep_locked[%0d]: got %b want 1", i, bus_a.locked); end
      tests_run++; if (bus_a.dir !== exp_dir) begin tests_failed++; $display("FAIL sweep_dir[%0d]: got %b want %b", i, bus_a.dir, exp_dir); end
      tests_run++; if (bus_a.at_peak !== exp_peak) begin tests_failed++; $display("FAIL sweep_peak[%0d]: got %b want %b", i, bus_a.at_peak, exp_peak); end
      tests_run++; if (bus_a.at_trough !== exp_trough) begin tests_failed++; $display("FAIL sweep_trough[%0d]: got %b want %b", i, bus_a.at_trough, exp_trough); end
      tests_run++; if (bus_a.err !== 1'b0) begin tests_failed++; $display("FAIL sweep_err[%0d]: got %b want 0", i, bus_a.err); end
    end
    tests_run++; if (bus_a.trip_cnt !== 8'd1) begin tests_failed++; $display("FAIL sweep_trip: got %0d want 1", bus_a.trip_cnt); end
  endtask

  task automatic test_sync_ignore();
    do_reset();
    step(1'b1, 4'd3);
    tests_run++; if (bus_a.locked !== 1'b0) begin tests_failed++; $display("FAIL sync_3_locked: got %b want 0", bus_a.locked); end
    step(1'b1, 4'd4);
    tests_run++; if (bus_a.locked !== 1'b0) begin tests_failed++; $display("FAIL sync_4_locked: got %b want 0", bus_a.locked); end
    step(1'b1, 4'd6);
    tests_run++; if (bus_a.locked !== 1'b1) begin tests_failed++; $display("FAIL sync_6_locked: got %b want 1", bus_a.locked); end
    tests_run++; if (bus_a.dir !== 1'b1) begin tests_failed++; $display("FAIL sync_6_dir: got %b want 1", bus_a.dir); end
    tests_run++; if (bus_a.at_peak !== 1'b0) begin tests_failed++; $display("FAIL sync_6_peak: got %b want 0", bus_a.at_peak); end
    step(1'b1, 4'd5);
    tests_run++; if (bus_a.at_peak !== 1'b0) begin tests_failed++; $display("FAIL sync_5_peak: got %b want 0", bus_a.at_peak); end
    tests_run++; if (bus_a.err !== 1'b0) begin tests_failed++; $display("FAIL sync_5_err: got %b want 0", bus_a.err); end
    tests_run++; if (bus_a.locked !== 1'b1) begin tests_failed++; $display("FAIL sync_5_locked: got %b want 1", bus_a.locked); end
    // Out-of-range value while still searching for lock
    do_reset();
    step(1'b1, 4'd9);
    tests_run++; if (bus_a.err_code !== 2'd2) begin tests_failed++; $display("FAIL sync_oor_code: got %0d want 2", bus_a.err_code); end
    tests_run++; if (bus_a.err !== 1'b1) begin tests_failed++; $display("FAIL sync_oor_err: got %b want 1", bus_a.err); end
  endtask

  task automatic test_step_error();
    do_reset();
    step(1'b1, 4'd0);
    step(1'b1, 4'd1);
    step(1'b1, 4'd3);
    tests_run++; if (bus_a.err !== 1'b1) begin tests_failed++; $display("FAIL step_err: got %b want 1", bus_a.err); end
    tests_run++; if (bus_a.err_code !== 2'd1) begin tests_failed++; $display("FAIL step_code: got %0d want 1", bus_a.err_code); end
    tests_run++; if (bus_a.locked !== 1'b0) begin tests_failed++; $display("FAIL step_locked: got %b want 0", bus_a.locked); end
    // Legal-looking samples must not revive the checker or pulse anything.
    step(1'b1, 4'd4);
    step(1'b1, 4'd5);
    step(1'b1, 4'd6);
    tests_run++; if (bus_a.at_peak !== 1'b0) begin tests_failed++; $display("FAIL fault_peak: got %b want 0", bus_a.at_peak); end
    tests_run++; if (bus_a.locked !== 1'b0) begin tests_failed++; $display("FAIL fault_locked: got %b want 0", bus_a.locked); end
    tests_run++; if (bus_a.err_code !== 2'd1) begin tests_failed++; $display("FAIL fault_code_frozen: got %0d want 1", bus_a.err_code); end
    tests_run++; if (bus_a.err !== 1'b1) begin tests_failed++; $display("FAIL fault_err_sticky: got %b want 1", bus_a.err); end
    do_reset();
    tests_run++; if (bus_a.err !== 1'b0) begin tests_failed++; $display("FAIL step_rst_err: got %b want 0", bus_a.err); end
    tests_run++; if (bus_a.err_code !== 2'd0) begin tests_failed++; $display("FAIL step_rst_code: got %0d want 0", bus_a.err_code); end
  endtask

  task automatic test_range_and_dir();
    do_reset();
    for (int v = 0; v <= 6; v++) step(1'b1, 4'(v));
    step(1'b1, 4'd7);
    tests_run++; if (bus_a.err_code !== 2'd2) begin tests_failed++; $display("FAIL range_code: got %0d want 2", bus_a.err_code); end
    tests_run++; if (bus_a.locked !== 1'b0) begin tests_failed++; $display("FAIL range_locked: got %b want 0", bus_a.locked); end
    tests_run++; if (bus_a.at_trough !== 1'b0) begin tests_failed++; $display("FAIL range_trough: got %b want 0", bus_a.at_trough); end
    do_reset();
    step(1'b1, 4'd0);
    step(1'b1, 4'd1);
    step(1'b1, 4'd2);
    step(1'b1, 4'd1);
    tests_run++; if (bus_a.err_code !== 2'd3) begin tests_failed++; $display("FAIL dir_code: got %0d want 3", bus_a.err_code); end
    tests_run++; if (bus_a.err !== 1'b1) begin tests_failed++; $display("FAIL dir_err: got %b want 1", bus_a.err); end
    tests_run++; if (bus_a.dir !== 1'b0) begin tests_failed++; $display("FAIL dir_hold: got %b want 0", bus_a.dir); end
  endtask

  task automatic test_valid_gap();
    do_reset();
    step(1'b1, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'd9);
      tests_run++; if (bus_a.locked !== 1'b1) begin tests_failed++; $display("FAIL gap_locked[%0d]: got %b want 1", i, bus_a.locked); end
      tests_run++; if ((bus_a.at_peak | bus_a.at_trough) !== 1'b0) begin tests_failed++; $display("FAIL gap_pulse[%0d]: got %b%b want 00", i, bus_a.at_peak, bus_a.at_trough); end
      tests_run++; if (bus_a.err !== 1'b0) begin tests_failed++; $display("FAIL gap_err[%0d]: got %b want 0", i, bus_a.err); end
    end
    step(1'b1, 4'd1);
    step(1'b1, 4'd2);
    tests_run++; if (bus_a.err !== 1'b0) begin tests_failed++; $display("FAIL gap_after_err: got %b want 0", bus_a.err); end
    tests_run++; if (bus_a.locked !== 1'b1) begin tests_failed++; $display("FAIL gap_after_locked: got %b want 1", bus_a.locked); end
  endtask

  task automatic test_trip_saturate();
    logic [1:0] exp_b [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    do_reset();
    step(1'b1, 4'd0);
    for (int k = 0; k < 4; k++) begin
      sweep_tail();
      tests_run++; if (bus_b.trip_cnt !== exp_b[k]) begin tests_failed++; $display("FAIL trip_b[%0d]: got %0d want %0d", k, bus_b.trip_cnt, exp_b[k]); end
      tests_run++; if (bus_a.trip_cnt !== 8'(k + 1)) begin tests_failed++; $display("FAIL trip_a[%0d]: got %0d want %0d", k, bus_a.trip_cnt, k + 1); end
    end
  endtask

  task automatic test_rst_mid_sweep();
    do_reset();
    step(1'b1, 4'd0);
    sweep_tail();
    step(1'b1, 4'd1);
    step(1'b1, 4'd2);
    rst = 1'b1;
    step(1'b1, 4'd3);
    rst = 1'b0;
    tests_run++; if (bus_b.locked !== 1'b0) begin tests_failed++; $display("FAIL mid_locked: got %b want 0", bus_b.locked); end
    tests_run++; if (bus_b.dir !== 1'b0) begin tests_failed++; $display("FAIL mid_dir: got %b want 0", bus_b.dir); end
    tests_run++; if ((bus_b.at_peak | bus_b.at_trough) !== 1'b0) begin tests_failed++; $display("FAIL mid_pulse: got %b%b want 00", bus_b.at_peak, bus_b.at_trough); end
    tests_run++; if (bus_b.trip_cnt !== 2'd0) begin tests_failed++; $display("FAIL mid_trip: got %0d want 0", bus_b.trip_cnt); end
    tests_run++; if (bus_b.err !== 1'b0) begin tests_failed++; $display("FAIL mid_err: got %b want 0", bus_b.err); end
    tests_run++; if (bus_b.err_code !== 2'd0) begin tests_failed++; $display("FAIL mid_code: got %0d want 0", bus_b.err_code); end
    step(1'b1, 4'd4);  // in range, not LO/HI: still searching
    tests_run++; if (bus_b.locked !== 1'b0) begin tests_failed++; $display("FAIL mid_search: got %b want 0", bus_b.locked); end
    step(1'b1, 4'd0);
    tests_run++; if (bus_b.locked !== 1'b1) begin tests_failed++; $display("FAIL mid_relock: got %b want 1", bus_b.locked); end
    tests_run++; if (bus_b.dir !== 1'b0) begin tests_failed++; $display("FAIL mid_relock_dir: got %b want 0", bus_b.dir); end
    step(1'b1, 4'd1);
    tests_run++; if (bus_b.err !== 1'b0) begin tests_failed++; $display("FAIL mid_after_err: got %b want 0", bus_b.err); end
  endtask

  initial begin
    bus_a.in_valid = 1'b0;
    bus_a.count_in = 4'd0;
    bus_b.in_valid = 1'b0;
    bus_b.count_in = 4'd0;
    test_reset();
    test_full_sweep();
    test_sync_ignore();
    test_step_error();
    test_range_and_dir();
    test_valid_gap();
    test_trip_saturate();
    test_rst_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
